// File: rtl/demo_sequencer.sv
// Demo scene sequencer: fades scenes in and out, advancing on timeout, skip request or song section change.
// All outputs registered; inputs take effect on the next clk48 edge. No backpressure, frame_start paced.
module demo_sequencer #(
    parameter int FADE_STEP_FRAMES = 2,
    parameter int SCENE_FRAMES     = 600
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [7:0] songpos,
    input  logic       skip_req,
    output logic [1:0] scene,
    output logic [3:0] layer_en,
    output logic [3:0] fade,
    output logic       fading,
    output logic       scene_change
);

    typedef enum logic [1:0] {FADE_IN, SHOW, FADE_OUT, SWITCH} state_t;

    localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);
    localparam logic [9:0] SHOW_LAST = 10'(SCENE_FRAMES - 1);

    state_t     state, state_nxt;
    logic [3:0] step_cnt, step_nxt;
    logic [9:0] frame_cnt, frame_nxt;
    logic       skip_pending, skip_nxt;
    logic [1:0] last_section, last_nxt;
    logic [1:0] scene_nxt;
    logic [3:0] layer_nxt;
    logic [3:0] fade_nxt;
    logic       fading_nxt;
    logic       change_nxt;
    logic       step_done;
    logic       advance;
    logic       unused_songpos;

    assign unused_songpos = ^songpos[5:0];

    function automatic logic [3:0] layer_for(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0101;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    assign step_done = (step_cnt == STEP_LAST);
    // A skip arriving on the same cycle as the frame counts immediately.
    assign advance   = skip_pending || skip_req ||
                       (songpos[7:6] != last_section) || (frame_cnt == SHOW_LAST);

    always_comb begin
        state_nxt  = state;
        step_nxt   = step_cnt;
        frame_nxt  = frame_cnt;
        skip_nxt   = skip_pending | skip_req;
        last_nxt   = last_section;
        scene_nxt  = scene;
        layer_nxt  = layer_en;
        fade_nxt   = fade;
        change_nxt = 1'b0;
        case (state)
            FADE_IN: begin
                if (frame_start) begin
                    if (step_done) begin
                        step_nxt = 4'd0;
                        if (fade != 4'hF) fade_nxt = fade + 4'd1;
                        if (fade >= 4'd14) begin
                            state_nxt = SHOW;
                            frame_nxt = 10'd0;
                        end
                    end else begin
                        step_nxt = step_cnt + 4'd1;
                    end
                end
            end
            SHOW: begin
                if (frame_start) begin
                    frame_nxt = frame_cnt + 10'd1;
                    if (advance) begin
                        state_nxt = FADE_OUT;
                        step_nxt  = 4'd0;
                    end
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (step_done) begin
                        step_nxt = 4'd0;
                        if (fade != 4'h0) fade_nxt = fade - 4'd1;
                        if (fade <= 4'd1) state_nxt = SWITCH;
                    end else begin
                        step_nxt = step_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt  = FADE_IN;
                step_nxt   = 4'd0;
                scene_nxt  = scene + 2'd1;
                layer_nxt  = layer_for(scene + 2'd1);
                last_nxt   = songpos[7:6];
                skip_nxt   = 1'b0;
                change_nxt = 1'b1;
            end
        endcase
        fading_nxt = (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FADE_IN;
            step_cnt     <= 4'd0;
            frame_cnt    <= 10'd0;
            skip_pending <= 1'b0;
            last_section <= 2'd0;
            scene        <= 2'd0;
            layer_en     <= 4'b0001;
            fade         <= 4'd0;
            fading       <= 1'b1;
            scene_change <= 1'b0;
        end else begin
            state        <= state_nxt;
            step_cnt     <= step_nxt;
            frame_cnt    <= frame_nxt;
            skip_pending <= skip_nxt;
            last_section <= last_nxt;
            scene        <= scene_nxt;
            layer_en     <= layer_nxt;
            fade         <= fade_nxt;
            fading       <= fading_nxt;
            scene_change <= change_nxt;
        end
    end

endmodule
